// File: rtl/hamming_secded_pipeline_pkg.sv
// Shared definitions for the Hamming (7,4) + overall-parity SECDED pipeline:
// widths, codeword bit positions, codeword type and the encoder.
package hamming_secded_pipeline_pkg;

    localparam int DATA_W = 4;
    localparam int CODE_W = 8;

    // Codeword layout: {d4, d3, d2, p4, d1, p2, p1, p0}
    localparam int POS_P0 = 0;
    localparam int POS_P1 = 1;
    localparam int POS_P2 = 2;
    localparam int POS_D1 = 3;
    localparam int POS_P4 = 4;
    localparam int POS_D2 = 5;
    localparam int POS_D3 = 6;
    localparam int POS_D4 = 7;

    typedef logic [CODE_W-1:0] codeword_t;

    // Build the even-parity SECDED codeword for one data nibble (d1 = bit 0).
    function automatic codeword_t encode(input logic [DATA_W-1:0] d);
        codeword_t cw;
        cw         = '0;
        cw[POS_D1] = d[0];
        cw[POS_D2] = d[1];
        cw[POS_D3] = d[2];
        cw[POS_D4] = d[3];
        cw[POS_P1] = d[0] ^ d[1] ^ d[3];
        cw[POS_P2] = d[0] ^ d[2] ^ d[3];
        cw[POS_P4] = d[1] ^ d[2] ^ d[3];
        cw[POS_P0] = ^cw[CODE_W-1:1];
        return cw;
    endfunction

endpackage

// File: rtl/hamming_secded_pipeline_syndrome.sv
// Combinational syndrome and overall-parity evaluation of an 8-bit codeword.
module hamming_syndrome
    import hamming_secded_pipeline_pkg::*;
(
    input  logic [CODE_W-1:0] word_i,
    output logic              s1_o,
    output logic              s2_o,
    output logic              s3_o,
    output logic              st_o
);

    // Each syndrome bit covers the positions whose index has that bit set.
    always_comb begin
        s1_o = word_i[1] ^ word_i[3] ^ word_i[5] ^ word_i[7];
        s2_o = word_i[2] ^ word_i[3] ^ word_i[6] ^ word_i[7];
        s3_o = word_i[4] ^ word_i[5] ^ word_i[6] ^ word_i[7];
        st_o = ^word_i;
    end

endmodule

// File: rtl/hamming_secded_pipeline.sv
// Two-stage SECDED pipeline: stage 1 encodes the data word and captures the
// received codeword; stage 2 captures the corrected word and error flags.
module hamming_secded_pipeline
    import hamming_secded_pipeline_pkg::*;
(
    input  logic              reloj,
    input  logic              rst,
    input  logic [DATA_W-1:0] dato_entrada,
    input  logic [CODE_W-1:0] dato_error,
    output logic [CODE_W-1:0] palabra,
    output logic [CODE_W-1:0] recibido,
    output logic              s1,
    output logic              s2,
    output logic              s3,
    output logic              st,
    output logic              error_simple,
    output logic              error_doble,
    output logic [DATA_W-1:0] corregido,
    output logic [CODE_W-1:0] palabra_corregida,
    output logic              simplerror_detectado,
    output logic              doblerror_detectado,
    output logic              led_doblerror
);

    codeword_t         palabra_q, recibido_q;
    codeword_t         palabra_corregida_q, palabra_corregida_d;
    logic [DATA_W-1:0] corregido_q, corregido_d;
    logic              simple_q, doble_q, led_q;
    logic [2:0]        syndrome;

    // ---- stage 1: encode input data, capture received codeword ----
    // Input register stage.
    always_ff @(posedge reloj or posedge rst) begin
        if (rst) begin
            palabra_q  <= '0;
            recibido_q <= '0;
        end else begin
            palabra_q  <= encode(dato_entrada);
            recibido_q <= dato_error;
        end
    end

    hamming_syndrome u_syndrome (
        .word_i (recibido_q),
        .s1_o   (s1),
        .s2_o   (s2),
        .s3_o   (s3),
        .st_o   (st)
    );

    assign syndrome     = {s3, s2, s1};
    assign error_simple = st;
    assign error_doble  = ~st & (syndrome != 3'd0);

    // Flip the bit named by the syndrome only on a single error; a zero
    // syndrome with odd parity means p0 itself is the bad bit.
    always_comb begin
        palabra_corregida_d = recibido_q;
        if (error_simple) begin
            palabra_corregida_d[syndrome] = ~recibido_q[syndrome];
        end
        corregido_d = {palabra_corregida_d[POS_D4], palabra_corregida_d[POS_D3],
                       palabra_corregida_d[POS_D2], palabra_corregida_d[POS_D1]};
    end

    // ---- stage 2: corrected word and classification flags ----
    // Output register stage.
    always_ff @(posedge reloj or posedge rst) begin
        if (rst) begin
            palabra_corregida_q <= '0;
            corregido_q         <= '0;
            simple_q            <= 1'b0;
            doble_q             <= 1'b0;
            led_q               <= 1'b0;
        end else begin
            palabra_corregida_q <= palabra_corregida_d;
            corregido_q         <= corregido_d;
            simple_q            <= error_simple;
            doble_q             <= error_doble;
            led_q               <= error_doble;
        end
    end

    assign palabra              = palabra_q;
    assign recibido             = recibido_q;
    assign palabra_corregida    = palabra_corregida_q;
    assign corregido            = corregido_q;
    assign simplerror_detectado = simple_q;
    assign doblerror_detectado  = doble_q;
    assign led_doblerror        = led_q;

endmodule

// File: tb/tb_hamming_secded_pipeline.sv
// Directed and exhaustive single/double-flip bench for hamming_secded_pipeline.
module tb_hamming_secded_pipeline;
    import hamming_secded_pipeline_pkg::*;

    logic       reloj = 1'b0;
    logic       rst;
    logic [3:0] dato_entrada;
    logic [7:0] dato_error;
    logic [7:0] palabra, recibido, palabra_corregida;
    logic       s1, s2, s3, st, error_simple, error_doble;
    logic [3:0] corregido;
    logic       simplerror_detectado, doblerror_detectado, led_doblerror;

    int n_checks = 0;
    int n_err    = 0;

    localparam int NV = 16 * 8 + 16 * 28;
    logic [3:0] v_data [NV];
    logic [7:0] v_word [NV];
    logic [7:0] v_good [NV];
    logic [2:0] v_syn  [NV];
    logic       v_dbl  [NV];

    hamming_secded_pipeline dut (
        .reloj                (reloj),
        .rst                  (rst),
        .dato_entrada         (dato_entrada),
        .dato_error           (dato_error),
        .palabra              (palabra),
        .recibido             (recibido),
        .s1                   (s1),
        .s2                   (s2),
        .s3                   (s3),
        .st                   (st),
        .error_simple         (error_simple),
        .error_doble          (error_doble),
        .corregido            (corregido),
        .palabra_corregida    (palabra_corregida),
        .simplerror_detectado (simplerror_detectado),
        .doblerror_detectado  (doblerror_detectado),
        .led_doblerror        (led_doblerror)
    );

    always #5 reloj = ~reloj;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".palabra"}, palabra, 8'h00);
        check({tag, ".recibido"}, recibido, 8'h00);
        check({tag, ".pcorr"}, palabra_corregida, 8'h00);
        check({tag, ".corregido"}, 8'(corregido), 8'h00);
        check({tag, ".flags"}, {1'b0, s3, s2, s1, st, simplerror_detectado,
                                doblerror_detectado, led_doblerror}, 8'h00);
        check({tag, ".cls"}, {6'b0, error_simple, error_doble}, 8'h00);
    endtask

    task automatic apply(input logic [3:0] din, input logic [7:0] derr);
        @(negedge reloj);
        dato_entrada = din;
        dato_error   = derr;
        @(posedge reloj);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        dato_entrada = 4'b0110;
        dato_error   = 8'hFF;
        #12;
        check_all_zero("reset");
        @(negedge reloj);
        rst = 1'b0;

        // No error
        apply(4'b1010, 8'b10100101);
        check("ne.palabra", palabra, 8'b10100101);
        check("ne.syn", {5'b0, s3, s2, s1}, 8'd0);
        check("ne.st", 8'(st), 8'd0);
        @(posedge reloj); #1;
        check("ne.corregido", 8'(corregido), 8'b1010);
        check("ne.flags", {5'b0, simplerror_detectado, doblerror_detectado, led_doblerror}, 8'd0);

        // Single data-bit error at position 5
        apply(4'b0010, 8'b00010011);
        check("se.palabra", palabra, 8'b00110011);
        check("se.syn", {5'b0, s3, s2, s1}, 8'd5);
        check("se.st", 8'(st), 8'd1);
        check("se.esimple", 8'(error_simple), 8'd1);
        @(posedge reloj); #1;
        check("se.pcorr", palabra_corregida, 8'b00110011);
        check("se.corregido", 8'(corregido), 8'b0010);
        check("se.sdet", 8'(simplerror_detectado), 8'd1);

        // Double error
        apply(4'b1101, 8'b00001100);
        check("de.palabra", palabra, 8'b11001100);
        check("de.syn", {5'b0, s3, s2, s1}, 8'd1);
        check("de.st", 8'(st), 8'd0);
        check("de.edoble", 8'(error_doble), 8'd1);
        @(posedge reloj); #1;
        check("de.ddet_led", {6'b0, doblerror_detectado, led_doblerror}, 8'b11);
        check("de.pcorr", palabra_corregida, 8'b00001100);
        check("de.corregido", 8'(corregido), 8'b0001);

        // p0-only error
        apply(4'b1010, 8'b10100100);
        check("p0.syn", {5'b0, s3, s2, s1}, 8'd0);
        check("p0.st", 8'(st), 8'd1);
        @(posedge reloj); #1;
        check("p0.pcorr", palabra_corregida, 8'b10100101);
        check("p0.flags", {6'b0, simplerror_detectado, doblerror_detectado}, 8'b10);

        // Exhaustive single and double flips, streamed one per cycle
        begin
            int k = 0;
            for (int d = 0; d < 16; d++) begin
                for (int i = 0; i < 8; i++) begin
                    v_data[k] = 4'(d);
                    v_good[k] = encode(4'(d));
                    v_word[k] = v_good[k] ^ (8'b1 << i);
                    v_syn[k]  = 3'(i);
                    v_dbl[k]  = 1'b0;
                    k++;
                end
                for (int i = 0; i < 8; i++) begin
                    for (int j = i + 1; j < 8; j++) begin
                        v_data[k] = 4'(d);
                        v_good[k] = encode(4'(d));
                        v_word[k] = v_good[k] ^ (8'b1 << i) ^ (8'b1 << j);
                        v_syn[k]  = 3'(i) ^ 3'(j);
                        v_dbl[k]  = 1'b1;
                        k++;
                    end
                end
            end
        end
        for (int k = 0; k <= NV; k++) begin
            if (k < NV) apply(v_data[k], v_word[k]);
            else begin @(posedge reloj); #1; end
            if (k < NV) begin
                check("ex.syn", {5'b0, s3, s2, s1}, {5'b0, v_syn[k]});
                check("ex.cls", {6'b0, error_simple, error_doble}, {6'b0, ~v_dbl[k], v_dbl[k]});
            end
            if (k >= 1) begin
                if (v_dbl[k-1]) begin
                    check("ex.ddet", 8'(doblerror_detectado), 8'd1);
                    check("ex.dpass", palabra_corregida, v_word[k-1]);
                end else begin
                    check("ex.corregido", 8'(corregido), 8'(v_data[k-1]));
                    check("ex.pcorr", palabra_corregida, v_good[k-1]);
                end
            end
        end

        // Reset asserted between edges mid-stream
        apply(4'b0010, 8'b00010011);
        @(posedge reloj);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge reloj);
        dato_entrada = 4'b1010;
        dato_error   = 8'b10100101;
        rst          = 1'b0;
        @(posedge reloj); #1;
        check("rel1.palabra", palabra, 8'b10100101);
        check("rel1.recibido", recibido, 8'b10100101);
        check("rel1.pcorr", palabra_corregida, 8'h00);
        @(posedge reloj); #1;
        check("rel2.pcorr", palabra_corregida, 8'b10100101);
        check("rel2.corregido", 8'(corregido), 8'b1010);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hamming_secded_pipeline.md
HAMMING_SECDED_PIPELINE -- requirements
Module: hamming_secded_pipeline

Interface
REQ-001 The module SHALL have these parameters: none; width fixed at 4 data bits and an 8-bit codeword, Hamming (7,4) plus overall parity.
REQ-002 The module SHALL have one clock and an asynchronous, active-high reset, with these ports:
- reloj  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- dato_entrada  in  4  data word to encode.
- dato_error  in  8  received codeword with any injected errors; this is the word itself, not an XOR mask.
- palabra  out  8  registered encoded codeword.
- recibido  out  8  registered copy of dato_error.
- s1, s2, s3  out  1 each  Hamming syndrome bits; syndrome value = {s3,s2,s1}.
- st  out  1  overall parity check, XOR of all 8 bits of recibido.
- error_simple  out  1  single error classified from the current recibido.
- error_doble  out  1  double error classified from the current recibido.
- corregido  out  4  corrected data bits.
- palabra_corregida  out  8  corrected codeword.
- simplerror_detectado  out  1  registered single-error flag.
- doblerror_detectado  out  1  registered double-error flag.
- led_doblerror  out  1  double-error LED drive, equal to doblerror_detectado.

Function
REQ-003 The codeword layout SHALL be: bit7=d4, bit6=d3, bit5=d2, bit4=p4, bit3=d1, bit2=p2, bit1=p1, bit0=p0, with d1=dato_entrada[0] through d4=dato_entrada[3].
REQ-004 The encoder parity bits SHALL be:
- p1 = d1^d2^d4
- p2 = d1^d3^d4
- p4 = d2^d3^d4
- p0 = XOR of bits 7..1, giving even overall parity.
REQ-005 Stage 1 SHALL register the inputs on each rising reloj edge: palabra <= encode(dato_entrada) and recibido <= dato_error, giving latency 1 cycle.
REQ-006 The syndromes SHALL be combinational from the registered recibido (r), and so are valid in the same cycle as recibido:
- s1 = r1^r3^r5^r7
- s2 = r2^r3^r6^r7
- s3 = r4^r5^r6^r7
- st = XOR r7..r0
REQ-007 Error classification SHALL be:
- error_simple = st.
- error_doble = (st==0) AND ({s3,s2,s1}!=0).
- No error when both flags are 0.
REQ-008 Correction:
- On a single error, the module SHALL invert the bit of recibido at index {s3,s2,s1}; index 0 means p0 is in error.
- Otherwise, the module SHALL pass recibido through unchanged.
REQ-009 On a double error, the module SHALL NOT alter any bit; corregido then carries the uncorrected data bits.
REQ-010 Stage 2 SHALL register, one cycle after stage 1 (latency 2 cycles from the inputs):
- palabra_corregida <= corrected word
- corregido <= {bit7,bit5? no: bit7,bit6,bit5,bit3} of the corrected word, i.e. {d4,d3,d2,d1}
- simplerror_detectado <= error_simple
- doblerror_detectado <= error_doble
- led_doblerror <= error_doble
REQ-011 The pipeline SHALL have no stall or handshake: a new input pair is accepted on every cycle, and results stream out at latency 1 for stage 1 and latency 2 for stage 2.
REQ-012 Errors of three or more bits SHALL be classified per REQ-007 without any further detection; miscorrection in that case is acceptable.

Reset
REQ-013 While rst=1, all registered outputs SHALL be 0, asynchronously: palabra, recibido, corregido, palabra_corregida, simplerror_detectado, doblerror_detectado and led_doblerror. The syndromes, error_simple and error_doble then evaluate to 0.
REQ-014 On rst deassertion, the first valid stage-1 output SHALL appear after the first rising edge, and the first valid stage-2 output after the second.

Structure
REQ-015 A shared package SHALL hold:
- the constants DATA_W=4 and CODE_W=8
- the bit-position constants for p0, p1, p2, p4, d1, d2, d3 and d4
- a typedef for the codeword
- an encode function used by both the RTL and the bench.
REQ-016 One combinational sub-module, hamming_syndrome, SHALL compute s1, s2, s3 and st from an 8-bit word; the encoder, register stages and correction SHALL be inline.

Verification
REQ-017 No-error case: dato_entrada=1010 and dato_error=10100101 -> palabra=10100101, syndrome=000, st=0, corregido=1010, both flags 0, led_doblerror=0.
REQ-018 Single data-bit error: dato_entrada=0010 and dato_error=00010011 -> palabra=00110011, syndrome=101, st=1, error_simple=1, palabra_corregida=00110011, corregido=0010.
REQ-019 Double error: dato_entrada=1101 and dato_error=00001100 -> palabra=11001100, syndrome=001, st=0, error_doble=1, doblerror_detectado=led_doblerror=1, palabra_corregida=00001100.
REQ-020 p0-only error: dato_error=10100101 with bit0 inverted (10100100) -> syndrome=000, st=1, single error, palabra_corregida=10100101.
REQ-021 Exhaustive check: for all 16 data values and every single-bit flip of encode(data), corregido SHALL equal data two cycles later; for every two-bit flip, error_doble SHALL be 1.
REQ-022 Reset mid-stream: asserting rst between edges SHALL clear all outputs immediately; after release, outputs SHALL follow REQ-014.
